// File: rtl/alu_logic_stage.sv
// alu_logic_stage: registered AND/OR/XOR/NOT execute stage feeding a 2-entry skid buffer.
// Optional macro ALU_LOGIC_STAGE_PARITY_EN stores and drives even parity P of each result.
module alu_logic_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Z,
  output logic             N,
  output logic [1:0]       op_out,
  output logic             P
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  function automatic logic [WIDTH-1:0] logic_result(input logic [1:0] f_op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (f_op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  logic [1:0]       count_r;
  logic [1:0]       count_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] main_y_r;
  logic             main_z_r;
  logic             main_n_r;
  logic [1:0]       main_op_r;
  logic [WIDTH-1:0] skid_y_r;
  logic             skid_z_r;
  logic             skid_n_r;
  logic [1:0]       skid_op_r;

  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] new_y_s;
  logic             new_z_s;
  logic             new_n_s;
  logic             load_main_new_s;
  logic             load_main_skid_s;
  logic             load_skid_s;

  assign push_s  = in_valid & in_ready_r;
  assign pop_s   = out_valid_r & out_ready;
  assign new_y_s = logic_result(op, A, B);
  assign new_z_s = (new_y_s == {WIDTH{1'b0}});
  assign new_n_s = new_y_s[WIDTH-1];

  // Next occupancy and which register loads what; flush overrides any push/pop.
  always_comb begin
    count_nxt_s      = count_r;
    load_main_new_s  = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      count_nxt_s = 2'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) begin
            load_main_new_s = 1'b1;
            count_nxt_s     = 2'd1;
          end else begin
            count_nxt_s = 2'd0;
          end
        end
        2'd1: begin
          if (push_s && !pop_s) begin
            load_skid_s = 1'b1;
            count_nxt_s = 2'd2;
          end else if (push_s && pop_s) begin
            load_main_new_s = 1'b1;
            count_nxt_s     = 2'd1;
          end else if (pop_s) begin
            count_nxt_s = 2'd0;
          end else begin
            count_nxt_s = 2'd1;
          end
        end
        2'd2: begin
          if (pop_s) begin
            load_main_skid_s = 1'b1;
            count_nxt_s      = 2'd1;
          end else begin
            count_nxt_s = 2'd2;
          end
        end
        default: count_nxt_s = 2'd0;
      endcase
    end
  end

  // Occupancy, handshake flags and the main/skid result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r     <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      main_y_r    <= {WIDTH{1'b0}};
      main_z_r    <= 1'b0;
      main_n_r    <= 1'b0;
      main_op_r   <= 2'b00;
      skid_y_r    <= {WIDTH{1'b0}};
      skid_z_r    <= 1'b0;
      skid_n_r    <= 1'b0;
      skid_op_r   <= 2'b00;
    end else begin
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s != 2'd2);
      out_valid_r <= (count_nxt_s != 2'd0);
      if (load_main_new_s) begin
        main_y_r  <= new_y_s;
        main_z_r  <= new_z_s;
        main_n_r  <= new_n_s;
        main_op_r <= op;
      end else if (load_main_skid_s) begin
        main_y_r  <= skid_y_r;
        main_z_r  <= skid_z_r;
        main_n_r  <= skid_n_r;
        main_op_r <= skid_op_r;
      end
      if (load_skid_s) begin
        skid_y_r  <= new_y_s;
        skid_z_r  <= new_z_s;
        skid_n_r  <= new_n_s;
        skid_op_r <= op;
      end
    end
  end

`ifdef ALU_LOGIC_STAGE_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic main_p_r;
  logic skid_p_r;
  logic new_p_s;

  assign new_p_s = even_parity(new_y_s);

  // Parity travels with its result through main and skid entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_p_r <= 1'b0;
      skid_p_r <= 1'b0;
    end else begin
      if (load_main_new_s) begin
        main_p_r <= new_p_s;
      end else if (load_main_skid_s) begin
        main_p_r <= skid_p_r;
      end
      if (load_skid_s) begin
        skid_p_r <= new_p_s;
      end
    end
  end

  assign P = main_p_r;
`else
  assign P = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Y         = main_y_r;
  assign Z         = main_z_r;
  assign N         = main_n_r;
  assign op_out    = main_op_r;

endmodule

// File: tb/tb_alu_logic_stage.sv
// Directed, table-driven bench for alu_logic_stage plus hand-written backpressure,
// flush and asynchronous-reset sequences.
module tb_alu_logic_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;
  logic        Z;
  logic        N;
  logic [1:0]  op_out;
  logic        P;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        z;
    logic        n;
    logic        p;
  } vec_t;

  vec_t vecs[8];

  alu_logic_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .Z(Z), .N(N), .op_out(op_out), .P(P)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_parity(input logic p);
`ifdef ALU_LOGIC_STAGE_PARITY_EN
    return p;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op = o;
    A = a;
    B = b;
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'hA5A5F00F, 32'h0F0F0F0F, 32'h0505000F, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 32'hA5A5F00F, 32'h0F0F0F0F, 32'hAFAFFF0F, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'b10, 32'hA5A5F00F, 32'h0F0F0F0F, 32'hAAAAFF00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 32'hA5A5F00F, 32'h0F0F0F0F, 32'h5A5A0FF0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b00, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; A = 32'h0; B = 32'h0;
    step();
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst Y", Y, 32'd0);
    chk("rst ZN", {30'd0, Z, N}, 32'd0);
    chk("rst op_out", {30'd0, op_out}, 32'd0);
    chk("rst P", {31'd0, P}, 32'd0);
    #2 rst = 1'b0;
    step();

    // Back-to-back pushes with the consumer always ready: one result per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("vec%0d Y", i), Y, vecs[i].y);
      chk($sformatf("vec%0d Z", i), {31'd0, Z}, {31'd0, vecs[i].z});
      chk($sformatf("vec%0d N", i), {31'd0, N}, {31'd0, vecs[i].n});
      chk($sformatf("vec%0d op_out", i), {30'd0, op_out}, {30'd0, vecs[i].op});
      chk($sformatf("vec%0d P", i), {31'd0, P}, {31'd0, exp_parity(vecs[i].p)});
    end
    in_valid = 1'b0;
    step();
    chk("drain out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain Y hold", Y, 32'h12345678);

    // Backpressure: two accepted, third held off until space returns.
    out_ready = 1'b0;
    drive(vecs[2].op, vecs[2].a, vecs[2].b);
    step();
    chk("bp1 in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp1 Y", Y, 32'hAAAAFF00);
    drive(vecs[1].op, vecs[1].a, vecs[1].b);
    step();
    chk("bp2 in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp2 Y", Y, 32'hAAAAFF00);
    drive(vecs[0].op, vecs[0].a, vecs[0].b);
    step();
    chk("bp3 in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp3 out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp3 Y hold", Y, 32'hAAAAFF00);
    chk("bp3 op_out hold", {30'd0, op_out}, 32'd2);
    out_ready = 1'b1;
    step();
    chk("bp4 Y second", Y, 32'hAFAFFF0F);
    chk("bp4 N", {31'd0, N}, 32'd1);
    chk("bp4 in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp5 Y third", Y, 32'h0505000F);
    chk("bp5 out_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp6 out_valid", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full and a concurrent push.
    out_ready = 1'b0;
    drive(vecs[2].op, vecs[2].a, vecs[2].b);
    step();
    drive(vecs[1].op, vecs[1].a, vecs[1].b);
    step();
    chk("fl pre in_ready", {31'd0, in_ready}, 32'd0);
    drive(vecs[3].op, vecs[3].a, vecs[3].b);
    flush = 1'b1;
    step();
    chk("fl out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl in_ready", {31'd0, in_ready}, 32'd1);
    chk("fl Y keep", Y, 32'hAAAAFF00);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl post out_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges with both entries full.
    out_ready = 1'b0;
    drive(vecs[2].op, vecs[2].a, vecs[2].b);
    step();
    drive(vecs[1].op, vecs[1].a, vecs[1].b);
    step();
    in_valid = 1'b0;
    chk("ar pre out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar in_ready", {31'd0, in_ready}, 32'd1);
    chk("ar Y", Y, 32'd0);
    #1 rst = 1'b0;
    drive(vecs[0].op, vecs[0].a, vecs[0].b);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("ar push out_valid", {31'd0, out_valid}, 32'd1);
    chk("ar push Y", Y, 32'h0505000F);
    step();
    chk("ar single out_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("ar idle out_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_logic_stage.md
Name: alu_logic_stage

Overview:
- Registered execute stage wrapping the 32-bit logic units (AND/OR/XOR/NOT) of the cpu32 datapath.
- Accepts an operation plus operands A/B through a valid/ready handshake, computes Y, Z and N, and holds results in a 2-entry skid buffer.
- Downstream (writeback/flags) drains results with its own valid/ready.
- Fully registered boundary: in_ready and all outputs come from flops.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  synchronous clear of all buffered results.
- in_valid  input  1  operation presented.
- in_ready  output  1  stage can accept this cycle.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOT(A); B ignored for NOT.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  result at head is valid.
- out_ready  input  1  consumer accepts head result.
- Y  output  WIDTH  result.
- Z  output  1  Y == 0.
- N  output  1  Y[WIDTH-1].
- op_out  output  2  op that produced Y.
- P  output  1  even parity of Y (see Optional Feature).

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-high. While rst is high: count=0, out_valid=0, in_ready=1, Y=0, Z=0, N=0, op_out=0, P=0. Skid entry is cleared.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid/A/B/op are sampled only on push. Y/Z/N/op_out/P hold stable while out_valid & !out_ready.
- Compute: result, Z, N (and P) are computed combinationally from the inputs and captured at push. Latency is 1 cycle: a push into an empty stage gives out_valid=1 on the next edge.
- Storage: main register drives the outputs; skid register holds a second result. count ∈ {0,1,2}. Ordering is strict FIFO.
- State transitions per edge (push, pop):
  - count 0: push → main=new, count=1.
  - count 1: push&!pop → skid=new, count=2. push&pop → main=new, count stays 1. !push&pop → count=0.
  - count 2: in_ready=0, so no push. pop → main=skid, count=1.
- Flags:
  - in_ready registered = (next_count != 2). out_valid registered = (next_count != 0).
- Flush: takes priority over push/pop. Next edge gives count=0, out_valid=0, in_ready=1. A concurrent in_valid is dropped. Y/Z/N/op_out/P keep their last values.
- rst mid-transfer discards all entries immediately, without waiting for a clock edge.
- No arithmetic or carry: bitwise only. Width rules are WIDTH in → WIDTH out.

Optional Feature:
- Macro: ALU_LOGIC_STAGE_PARITY_EN.
- Defined: P = XOR-reduction of Y. P is computed at push and stored per entry, including in the skid register.
- Undefined: no parity storage is built; P is tied to 0. Port list is identical in both builds.

Test Plan:
- A=A5A5F00F, B=0F0F0F0F, ops AND/OR/XOR/NOT back-to-back with out_ready=1 → Y = 0505000F, AFAFFF0F, AAAAFF00, 5A5A0FF0 on consecutive cycles; Z=0 each; N=0,1,1,0; in_ready stays 1.
- AND of FFFF0000 & 0000FFFF → Y=0, Z=1, N=0. NOT of A=00000000 → Y=FFFFFFFF, N=1, Z=0.
- Backpressure: out_ready=0, push 3 ops (XOR, OR, AND with the first vector) → first two accepted, in_ready=0 after the second; Y holds AAAAFF00. Raise out_ready → results drain in order AAAAFF00 then AFAFFF0F, and the third op is accepted when in_ready returns to 1.
- Fill both entries, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, incoming op is not output.
- Assert rst asynchronously between edges with count=2 → out_valid=0, in_ready=1 immediately. After release, a single push of AND yields exactly one result.
- Parity: macro defined, AND A=00000001 B=FFFFFFFF → P=1; AND with the first vector (0505000F) → P=0. Macro undefined → P=0 always.
